dmem_arbiter: RTL and testbench

- Shares a single-port, synchronous-read data memory between two requesters.
- Requester 1 is the pipeline MEM stage (CPU port). Requester 2 is a debug/loader port (DBG port), used for memory dump, program load and LED readout.
- The CPU has fixed priority, limited by a starvation counter that forces a DBG grant after a bounded wait.
- A memory read takes two cycles. The arbiter stalls the pipeline through cpu_stall until the access completes.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_starve_counter.sv | 42 ++++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e    : arbiter FSM state encoding (IDLE / CPU_RD / DBG_RD)
//   port_sel_e : which requester owns the memory port in the current cycle
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_DBG  = 2'd2
    } port_sel_e;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear, used to bound how long a
// low-priority requester can be denied.
//   clk    : clock
//   rst    : asynchronous active-low reset, clears the count
//   inc_i  : count one more denied cycle (saturates at LIMIT)
//   clr_i  : clear the count (has priority over inc_i)
//   cnt_o  : current count
module dmem_arbiter_starve_counter #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT_W)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port, synchronous-read data memory between the
// pipeline MEM stage (CPU port, fixed priority) and a debug/loader port (DBG).
// A starvation counter forces a DBG grant after STARVE_LIMIT denied cycles.
// Reads take two cycles (issue, return); writes complete in the grant cycle.
//   clk, rst            : clock, asynchronous active-low reset
//   halt                : suppresses CPU writes (granted but not performed)
//   cpu_req/we/addr/wdata, cpu_rdata, cpu_stall : CPU requester
//   dbg_req/we/addr/wdata, dbg_gnt, dbg_rvalid, dbg_rdata : DBG requester
//   mem_en/we/addr/wdata, mem_rdata : memory port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_W = CNT_WIDTH'(STARVE_LIMIT);

    state_e               state_q, state_d;
    port_sel_e            sel;
    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 dbg_win;
    logic                 cpu_done;

    // Arbitration only happens in IDLE; the counter lets DBG overtake a
    // continuously requesting CPU.
    always_comb begin
        sel = SEL_NONE;
        if (state_q == IDLE) begin
            if (dbg_req && (!cpu_req || (starve_cnt >= LIMIT_W))) begin
                sel = SEL_DBG;
            end else if (cpu_req) begin
                sel = SEL_CPU;
            end
        end
    end

    assign dbg_win = (sel == SEL_DBG);

    dmem_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .WIDTH (CNT_WIDTH)
    ) u_starve_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (dbg_req && !dbg_win),
        .clr_i (dbg_win || !dbg_req),
        .cnt_o (starve_cnt)
    );

    always_comb begin
        state_d    = state_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        cpu_rdata  = '0;
        cpu_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel == SEL_DBG) begin
                    mem_en    = 1'b1;
                    mem_we    = dbg_we;
                    mem_addr  = dbg_addr;
                    mem_wdata = dbg_wdata;
                    dbg_gnt   = 1'b1;
                    if (!dbg_we) state_d = DBG_RD;
                end else if (sel == SEL_CPU) begin
                    // A halted CPU write is acknowledged but never reaches memory.
                    if (!(cpu_we && halt)) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                    cpu_done = cpu_we;
                    if (!cpu_we) state_d = CPU_RD;
                end
            end
            CPU_RD: begin
                cpu_rdata = mem_rdata;
                cpu_done  = 1'b1;
                state_d   = IDLE;
            end
            DBG_RD: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_stall = cpu_req && !cpu_done;

        // Outputs are forced quiet for the whole reset window, independent
        // of whatever the requesters are driving.
        if (!rst) begin
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            dbg_gnt    = 1'b0;
            dbg_rvalid = 1'b0;
            dbg_rdata  = '0;
            cpu_rdata  = '0;
            cpu_stall  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          halt;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          dbg_gnt, dbg_rvalid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (4),
        .CNT_WIDTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .halt       (halt),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port synchronous-read memory model (small, address folded).
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rdata_q = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        rdata_q <= mem[mem_addr[7:0]];
        end
    end
    assign mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // ---- Reset: outputs quiet even with requests present
        rst_n = 1'b0; halt = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h10; cpu_wdata = 32'h1111_1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 24'h20; dbg_wdata = 32'h2222_2222;
        #2;
        check("rst_mem_en",    mem_en,    0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_dbg_gnt",   dbg_gnt,   0);
        repeat (2) @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_state",  dut.state_q, 0);
        check("post_rst_mem_en", mem_en,      0);
        check("post_rst_stall",  cpu_stall,   0);

        // ---- CPU write then read
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h10; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("cw_mem_we",    mem_we,    1);
        check("cw_mem_en",    mem_en,    1);
        check("cw_mem_addr",  mem_addr,  32'h10);
        check("cw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("cw_stall",     cpu_stall, 0);
        step();
        cpu_we = 1'b0;
        @(negedge clk);
        check("cr_issue_stall",  cpu_stall, 1);
        check("cr_issue_mem_en", mem_en,    1);
        check("cr_issue_mem_we", mem_we,    0);
        check("cr_issue_rdata0", cpu_rdata, 0);
        step();
        @(negedge clk);
        check("cr_ret_stall",  cpu_stall, 0);
        check("cr_ret_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        check("cr_ret_mem_en", mem_en,    0);
        step();
        cpu_req = 1'b0;

        // ---- Starvation: continuous CPU writes, DBG read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h40; cpu_wdata = 32'hA5A5_0000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 24'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("starve_gnt%0d", i),   dbg_gnt,   0);
            check($sformatf("starve_stall%0d", i), cpu_stall, 0);
            check($sformatf("starve_we%0d", i),    mem_we,    1);
            step();
            cpu_wdata = cpu_wdata + 1;
        end
        @(negedge clk);
        check("starve_forced_gnt",   dbg_gnt,   1);
        check("starve_forced_stall", cpu_stall, 1);
        check("starve_forced_addr",  mem_addr,  32'h10);
        check("starve_forced_we",    mem_we,    0);
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        check("starve_rvalid", dbg_rvalid, 1);
        check("starve_rdata",  dbg_rdata,  32'hDEAD_BEEF);
        check("starve_stall",  cpu_stall,  1);
        check("starve_gnt_rd", dbg_gnt,    0);
        step();
        @(negedge clk);
        check("resume_stall",  cpu_stall,      0);
        check("resume_we",     mem_we,         1);
        check("resume_rvalid", dbg_rvalid,     0);
        check("resume_cnt",    dut.starve_cnt, 0);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;

        // ---- DBG alone: write then read
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 24'h20; dbg_wdata = 32'h1234_5678;
        @(negedge clk);
        check("dw_gnt",   dbg_gnt,   1);
        check("dw_we",    mem_we,    1);
        check("dw_addr",  mem_addr,  32'h20);
        check("dw_stall", cpu_stall, 0);
        step();
        dbg_we = 1'b0;
        @(negedge clk);
        check("dr_gnt",    dbg_gnt,    1);
        check("dr_we",     mem_we,     0);
        check("dr_rvalid", dbg_rvalid, 0);
        check("dr_rdata0", dbg_rdata,  0);
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        check("dr_ret_rvalid", dbg_rvalid, 1);
        check("dr_ret_rdata",  dbg_rdata,  32'h1234_5678);
        step();

        // ---- Halt suppresses CPU write
        halt = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h20; cpu_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("halt_stall",  cpu_stall, 0);
        check("halt_mem_we", mem_we,    0);
        check("halt_mem_en", mem_en,    0);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 24'h20;
        @(negedge clk);
        check("halt_dr_gnt", dbg_gnt, 1);
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        check("halt_dr_rvalid", dbg_rvalid, 1);
        check("halt_dr_rdata",  dbg_rdata,  32'h1234_5678);
        step();
        halt = 1'b0;

        // ---- Reset during the CPU read return cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h10;
        @(negedge clk);
        check("rr_issue_stall", cpu_stall, 1);
        step();
        rst_n = 1'b0;
        #1;
        check("rr_rst_stall",  cpu_stall, 0);
        check("rr_rst_rdata",  cpu_rdata, 0);
        check("rr_rst_mem_en", mem_en,    0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rr_rel_rvalid", dbg_rvalid, 0);
        check("rr_rel_stall",  cpu_stall,  1);
        check("rr_rel_mem_en", mem_en,     1);
        check("rr_rel_mem_we", mem_we,     0);
        step();
        @(negedge clk);
        check("rr_ret_stall", cpu_stall, 0);
        check("rr_ret_rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("final_idle_mem_en", mem_en,    0);
        check("final_idle_rdata",  cpu_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
